// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared AND/OR/NOR/XOR unit with a
// single tagged result register and a running count of delivered results.
module logic_unit_arbiter #(
  parameter int unsigned REG_SIZE = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [1:0]          req0_op,
  input  logic [REG_SIZE-1:0] req0_a,
  input  logic [REG_SIZE-1:0] req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [1:0]          req1_op,
  input  logic [REG_SIZE-1:0] req1_a,
  input  logic [REG_SIZE-1:0] req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [REG_SIZE-1:0] rsp_data,
  output logic                rsp_zero,
  output logic [CNT_W-1:0]    done_count
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic [REG_SIZE-1:0] r_rsp_data;
  logic                r_rsp_id;
  logic                r_rsp_zero;
  logic [CNT_W-1:0]    r_done_count;

  logic                w_can_accept;
  logic                w_gnt_valid;
  logic                w_gnt_idx;
  logic                w_accept;
  logic                w_drain;
  logic [1:0]          w_sel_op;
  logic [REG_SIZE-1:0] w_sel_a;
  logic [REG_SIZE-1:0] w_sel_b;
  logic [REG_SIZE-1:0] w_result;

  // Round-robin pick: on contention, the requester not granted last wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_idx   = ~r_last_grant;
    end else if (req0_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_idx   = 1'b0;
    end else if (req1_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_idx   = 1'b1;
    end
  end

  // Result slot is free when empty or being drained this cycle.
  assign w_can_accept = !rst && ((r_state == ST_EMPTY) || rsp_ready);
  assign w_accept     = w_can_accept && w_gnt_valid;
  assign w_drain      = (r_state == ST_FULL) && rsp_ready;

  assign req0_ready = w_accept && !w_gnt_idx;
  assign req1_ready = w_accept &&  w_gnt_idx;

  // Operand mux feeding the single shared logic unit.
  always_comb begin
    w_sel_op = req0_op;
    w_sel_a  = req0_a;
    w_sel_b  = req0_b;
    if (w_gnt_idx) begin
      w_sel_op = req1_op;
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
    end
  end

  always_comb begin
    w_result = '0;
    case (w_sel_op)
      OP_AND:  w_result = w_sel_a & w_sel_b;
      OP_OR:   w_result = w_sel_a | w_sel_b;
      OP_NOR:  w_result = ~(w_sel_a | w_sel_b);
      OP_XOR:  w_result = w_sel_a ^ w_sel_b;
      default: w_result = '0;
    endcase
  end

  // Result-slot occupancy; an accept during a drain keeps the slot full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_zero   <= 1'b1;
      r_done_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_data   <= w_result;
        r_rsp_id     <= w_gnt_idx;
        r_rsp_zero   <= (w_result == '0);
        r_last_grant <= w_gnt_idx;
      end
      if (w_drain) begin
        r_done_count <= r_done_count + CNT_W'(1);
      end
    end
  end

  assign rsp_valid  = (r_state == ST_FULL);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign done_count = r_done_count;

endmodule
